// File: rtl/scalar_mult_ctrl.sv
// Double-and-add scalar multiplication sequencer driving an external combinational point ALU.
// Optional SCALAR_MULT_LEADING_ZERO_SKIP_EN: start from the highest set bit of k with Q=P.
module scalar_mult_ctrl #(
    parameter int K_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [K_WIDTH-1:0] k,
    input  logic [11:0]        P,
    output logic               busy,
    output logic               done,
    output logic [11:0]        Q,
    output logic [1:0]         alu_op,
    output logic [11:0]        alu_A,
    output logic [11:0]        alu_B,
    input  logic [11:0]        alu_R
);

    localparam int          IW  = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;
    localparam logic [11:0] INF = 12'h010;
    localparam logic [1:0]  OP_ADD = 2'b00;
    localparam logic [1:0]  OP_DBL = 2'b01;

    typedef enum logic [1:0] {S_IDLE, S_DBL, S_ADD, S_DONE} state_t;

    state_t             r_state_reg, w_state_next;
    logic [11:0]        r_q_reg, w_q_next;
    logic [11:0]        r_p_reg, w_p_next;
    logic [K_WIDTH-1:0] r_k_reg, w_k_next;
    logic [IW-1:0]      r_i_reg, w_i_next;
    logic               w_bit;

    assign w_bit = r_k_reg[r_i_reg];

`ifdef SCALAR_MULT_LEADING_ZERO_SKIP_EN
    logic [IW-1:0] w_msb;
    logic          w_k_nz;

    // Priority encoder: the last set bit scanned upward wins, giving the MSB index.
    always_comb begin
        w_msb = '0;
        for (int j = 0; j < K_WIDTH; j++) begin
            if (k[j]) w_msb = j[IW-1:0];
        end
    end
    assign w_k_nz = |k;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_reg <= S_IDLE;
            r_q_reg     <= INF;
            r_p_reg     <= '0;
            r_k_reg     <= '0;
            r_i_reg     <= '0;
        end else begin
            r_state_reg <= w_state_next;
            r_q_reg     <= w_q_next;
            r_p_reg     <= w_p_next;
            r_k_reg     <= w_k_next;
            r_i_reg     <= w_i_next;
        end
    end

    always_comb begin
        w_state_next = r_state_reg;
        w_q_next     = r_q_reg;
        w_p_next     = r_p_reg;
        w_k_next     = r_k_reg;
        w_i_next     = r_i_reg;
        alu_op       = OP_ADD;
        case (r_state_reg)
            S_IDLE: begin
                if (start) begin
                    w_k_next = k;
                    w_p_next = P;
`ifdef SCALAR_MULT_LEADING_ZERO_SKIP_EN
                    // The leading one is absorbed by loading P directly.
                    if (!w_k_nz) begin
                        w_q_next     = INF;
                        w_i_next     = '0;
                        w_state_next = S_DONE;
                    end else begin
                        w_q_next = P;
                        if (w_msb == '0) begin
                            w_i_next     = '0;
                            w_state_next = S_DONE;
                        end else begin
                            w_i_next     = w_msb - 1'b1;
                            w_state_next = S_DBL;
                        end
                    end
`else
                    w_q_next     = INF;
                    w_i_next     = IW'(K_WIDTH - 1);
                    w_state_next = S_DBL;
`endif
                end
            end
            S_DBL: begin
                alu_op   = OP_DBL;
                w_q_next = alu_R;
                if (w_bit) begin
                    w_state_next = S_ADD;
                end else if (r_i_reg == '0) begin
                    w_state_next = S_DONE;
                end else begin
                    w_i_next     = r_i_reg - 1'b1;
                    w_state_next = S_DBL;
                end
            end
            S_ADD: begin
                alu_op   = OP_ADD;
                w_q_next = alu_R;
                if (r_i_reg == '0) begin
                    w_state_next = S_DONE;
                end else begin
                    w_i_next     = r_i_reg - 1'b1;
                    w_state_next = S_DBL;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign busy  = (r_state_reg != S_IDLE);
    assign done  = (r_state_reg == S_DONE);
    assign Q     = r_q_reg;
    assign alu_A = r_q_reg;
    assign alu_B = r_p_reg;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Scoreboard bench for scalar_mult_ctrl with a toy point ALU that honours the INF identities.
module tb_scalar_mult_ctrl;

    localparam int          KW  = 4;
    localparam logic [11:0] INF = 12'h010;

`ifdef SCALAR_MULT_LEADING_ZERO_SKIP_EN
    localparam logic [31:0] S1011 = 32'b11010;    localparam int L1011 = 5;
    localparam logic [31:0] S1000 = 32'b111;      localparam int L1000 = 3;
    localparam logic [31:0] S1111 = 32'b101010;   localparam int L1111 = 6;
    localparam logic [31:0] S0000 = 32'b0;        localparam int L0000 = 0;
`else
    localparam logic [31:0] S1011 = 32'b1011010;  localparam int L1011 = 7;
    localparam logic [31:0] S1000 = 32'b10111;    localparam int L1000 = 5;
    localparam logic [31:0] S1111 = 32'b10101010; localparam int L1111 = 8;
    localparam logic [31:0] S0000 = 32'b1111;     localparam int L0000 = 4;
`endif

    logic          clk = 1'b0;
    logic          rst, start;
    logic [KW-1:0] k;
    logic [11:0]   P, Q, alu_A, alu_B, alu_R;
    logic          busy, done;
    logic [1:0]    alu_op;

    scalar_mult_ctrl #(.K_WIDTH(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .k(k), .P(P),
        .busy(busy), .done(done), .Q(Q), .alu_op(alu_op),
        .alu_A(alu_A), .alu_B(alu_B), .alu_R(alu_R)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] f_dbl(input logic [11:0] a);
        if (a == INF) return INF;
        return {a[10:0], a[11]} + 12'h031;
    endfunction

    function automatic logic [11:0] f_add(input logic [11:0] a, input logic [11:0] b);
        if (a == INF) return b;
        return (a + b) ^ 12'h5A5;
    endfunction

    always_comb alu_R = (alu_op == 2'b01) ? f_dbl(alu_A) : f_add(alu_A, alu_B);

    typedef struct {
        logic [11:0] q;
        logic [11:0] p;
        logic [31:0] seq;
        int          len;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_done  = 0;
    logic [31:0] last_seq;
    int          last_len;

    // Plain left-to-right double-and-add from INF: the reference result in every build.
    function automatic logic [11:0] ref_q(input logic [KW-1:0] kv, input logic [11:0] pv);
        logic [11:0] q = INF;
        for (int j = KW - 1; j >= 0; j--) begin
            q = f_dbl(q);
            if (kv[j]) q = f_add(q, pv);
        end
        return q;
    endfunction

    function automatic exp_t model(input logic [KW-1:0] kv, input logic [11:0] pv);
        exp_t e;
        int   top;
        e.p   = pv;
        e.seq = '0;
        e.len = 0;
        e.q   = ref_q(kv, pv);
`ifdef SCALAR_MULT_LEADING_ZERO_SKIP_EN
        top = -1;
        for (int j = 0; j < KW; j++) if (kv[j]) top = j;
        top = top - 1;
`else
        top = KW - 1;
`endif
        for (int j = top; j >= 0; j--) begin
            e.seq = {e.seq[30:0], 1'b1};
            e.len++;
            if (kv[j]) begin
                e.seq = {e.seq[30:0], 1'b0};
                e.len++;
            end
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: pushes on accepted start, pops and compares on done.
    always @(negedge clk) begin
        static logic        prev_done = 1'b0;
        static logic        active    = 1'b0;
        static int          cnt       = 0;
        static int          olen      = 0;
        static logic [31:0] oseq      = '0;
        exp_t e;
        if (rst) begin
            sb.delete();
            active = 1'b0;
        end else begin
            if (active) begin
                cnt++;
                if (busy && !done) begin
                    oseq = {oseq[30:0], alu_op[0]};
                    olen++;
                end
            end
            if (done) begin
                check("done_not_adjacent", {31'd0, prev_done}, 32'd0);
                check("done_expected", {31'd0, (sb.size() > 0)}, 32'd1);
                n_done++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("result_Q", Q, e.q);
                    check("captured_P", alu_B, e.p);
                    check("op_count", olen, e.len);
                    check("op_seq", oseq, e.seq);
                    check("latency", cnt, e.len + 1);
                    $display("[TB] run P=%h Q=%h ops=%0d seq=%b cycles=%0d", e.p, Q, olen, oseq, cnt);
                end
                last_seq = oseq;
                last_len = olen;
                active   = 1'b0;
            end
            if (start && !busy) begin
                sb.push_back(model(k, P));
                active = 1'b1;
                cnt    = 0;
                olen   = 0;
                oseq   = '0;
            end
        end
        prev_done = done;
    end

    task automatic start_run(input logic [KW-1:0] kv, input logic [11:0] pv);
        @(posedge clk); #1;
        start = 1'b1; k = kv; P = pv;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
`ifdef SCALAR_MULT_LEADING_ZERO_SKIP_EN
        check("Q_at_t0", Q, (kv != '0) ? {20'd0, pv} : {20'd0, INF});
`else
        check("Q_at_t0", Q, {20'd0, INF});
`endif
    endtask

    task automatic wait_done(input int d0);
        int c = 0;
        while (n_done == d0 && c < 200) begin
            @(posedge clk);
            c++;
        end
        check("done_within_budget", {31'd0, (n_done != d0)}, 32'd1);
    endtask

    task automatic run(input logic [KW-1:0] kv, input logic [11:0] pv);
        int d0 = n_done;
        start_run(kv, pv);
        wait_done(d0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; k = '0; P = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_Q", Q, {20'd0, INF});
        check("rst_alu_op", {30'd0, alu_op}, 32'd0);
        check("rst_alu_A", alu_A, {20'd0, INF});
        check("rst_alu_B", alu_B, 32'd0);
        rst = 1'b0;

        run(4'b1011, 12'h5A3);
        check("seq_1011", last_seq, S1011);
        check("len_1011", last_len, L1011);
        run(4'b1000, 12'h9C7);
        check("seq_1000", last_seq, S1000);
        check("len_1000", last_len, L1000);
        run(4'b1111, 12'hB21);
        check("seq_1111", last_seq, S1111);
        check("len_1111", last_len, L1111);
        run(4'b0000, 12'hD44);
        check("seq_0000", last_seq, S0000);
        check("len_0000", last_len, L0000);
        check("Q_0000", Q, {20'd0, INF});
        run(4'b0001, 12'h8E9);

        for (int r = 0; r < 6; r++) begin
            run(KW'($urandom_range(0, (1 << KW) - 1)), 12'($urandom) | 12'h800);
        end

        // Reset in the middle of a run.
        d0 = n_done;
        start_run(4'b1011, 12'hA5C);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_Q", Q, {20'd0, INF});
        check("midrst_alu_B", alu_B, 32'd0);
        repeat (10) @(posedge clk);
        check("midrst_no_done", n_done, d0);
        run(4'b1011, 12'hA5C);

        // Start pulse while busy must be ignored.
        d0 = n_done;
        start_run(4'b1011, 12'hC3E);
        @(posedge clk); #1;
        start = 1'b1; k = 4'b0001; P = 12'h8FF;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(d0);
        repeat (12) @(posedge clk);
        check("busy_start_one_done", n_done, d0 + 1);
        check("busy_start_Q", Q, ref_q(4'b1011, 12'hC3E));
        check("busy_start_P", alu_B, 12'hC3E);

        // Start held high: restart in the IDLE cycle after each DONE.
        d0 = n_done;
        @(posedge clk); #1;
        start = 1'b1; k = 4'b0101; P = 12'h9A6;
        for (int r = 0; r < 3; r++) begin
            wait_done(d0 + r);
            if (r < 2) begin
                #1;
                check("b2b_idle_gap", {31'd0, busy}, 32'd0);
                @(posedge clk); #1;
                check("b2b_reaccept", {31'd0, busy}, 32'd1);
            end
        end
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        check("b2b_done_count", n_done, d0 + 3);
        check("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
